// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_pkg : shared types and default sizes for the data cache       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dcache_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 16;
   localparam int INDEX_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   function automatic int tag_w(input int addr_w, input int index_w);
      return addr_w - index_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_if : pipeline MEM-stage port plus external memory handshake   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dcache_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_dataout;
   logic [DATA_W-1:0] d_datain;
   logic              hit;
   logic              miss;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   // master: the environment (pipeline and memory); slave: the cache controller
   modport master (
      output d_req, d_we, d_addr, d_dataout, mem_rdata, mem_ack,
      input  d_datain, hit, miss, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  d_req, d_we, d_addr, d_dataout, mem_rdata, mem_ack,
      output d_datain, hit, miss, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_array : valid/tag/data storage, async read, one sync write    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dcache_array #(
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 12,
   parameter int DATA_W  = 16
) (
   input  wire logic               clk_i,
   input  wire logic               rst_ni,
   input  wire logic [INDEX_W-1:0] rd_idx_i,
   output logic                    rd_valid_o,
   output logic      [TAG_W-1:0]   rd_tag_o,
   output logic      [DATA_W-1:0]  rd_data_o,
   input  wire logic               we_i,
   input  wire logic [INDEX_W-1:0] wr_idx_i,
   input  wire logic               wr_valid_i,
   input  wire logic [TAG_W-1:0]   wr_tag_i,
   input  wire logic [DATA_W-1:0]  wr_data_i
);
   localparam int NLINES = 1 << INDEX_W;

   logic [NLINES-1:0] valid_q;
   logic [TAG_W-1:0]  tag_q  [NLINES];
   logic [DATA_W-1:0] data_q [NLINES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   // Tag and data contents survive reset; only the valid bits are cleared.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_ctrl : direct-mapped write-through no-allocate data cache;    |
// | optional DCACHE_STATS_EN adds hit/miss counters.  Rev 1.0            |
// +----------------------------------------------------------------------+
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  wire logic  clk_i,
   input  wire logic  rst_ni,
   dcache_if.slave    bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0] hit_cnt_o,
   output logic [15:0] miss_cnt_o
`endif
);
   localparam int TAG_W = tag_w(ADDR_W, INDEX_W);

   state_e              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   d_datain_q;
   logic                wr_done_q, wr_done_d;

   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [DATA_W-1:0]   rd_data;
   logic                lookup_hit;
   logic                hit, miss;
   logic                arr_we;
   logic [INDEX_W-1:0]  arr_idx;
   logic [TAG_W-1:0]    arr_tag;
   logic [DATA_W-1:0]   arr_data;

   dcache_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_array (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rd_idx_i   (bus.d_addr[INDEX_W-1:0]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (arr_we),
      .wr_idx_i   (arr_idx),
      .wr_valid_i (1'b1),
      .wr_tag_i   (arr_tag),
      .wr_data_i  (arr_data)
   );

   assign lookup_hit = rd_valid && (rd_tag == bus.d_addr[ADDR_W-1:INDEX_W]);

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wr_done_d   = wr_done_q;
      hit         = 1'b0;
      miss        = 1'b0;
      arr_we      = 1'b0;
      arr_idx     = bus.d_addr[INDEX_W-1:0];
      arr_tag     = bus.d_addr[ADDR_W-1:INDEX_W];
      arr_data    = bus.d_dataout;
      case (state_q)
         ST_IDLE: begin
            // A completed store stays retired until the pipeline moves on.
            if (!bus.d_req || (bus.d_addr != mem_addr_q)) wr_done_d = 1'b0;
            if (bus.d_req && !bus.d_we) begin
               if (lookup_hit) begin
                  hit = 1'b1;
               end else begin
                  miss       = 1'b1;
                  state_d    = ST_FILL;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.d_addr;
                  wr_done_d  = 1'b0;
               end
            end else if (bus.d_req && !(wr_done_q && (bus.d_addr == mem_addr_q))) begin
               miss        = 1'b1;
               state_d     = ST_WRITE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_dataout;
               arr_we      = lookup_hit;
            end
         end
         ST_FILL: begin
            miss     = bus.d_req;
            arr_idx  = mem_addr_q[INDEX_W-1:0];
            arr_tag  = mem_addr_q[ADDR_W-1:INDEX_W];
            arr_data = bus.mem_rdata;
            if (bus.mem_ack) begin
               arr_we    = 1'b1;
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_WRITE: begin
            miss = bus.d_req;
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               wr_done_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         d_datain_q  <= '0;
         wr_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wr_done_q   <= wr_done_d;
         if (hit) d_datain_q <= rd_data;
      end
   end

   assign bus.hit       = hit;
   assign bus.miss      = miss;
   assign bus.d_datain  = hit ? rd_data : d_datain_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
         if ((state_q == ST_IDLE) && (state_d == ST_FILL) && (miss_cnt_q != 16'hFFFF))
            miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the pipeline's MEM stage (d_addr / d_we / d_dataout) and the external data memory.
- Returns read data to the pipeline as d_datain, with hit and miss indications.
- Raises miss to stall the pipeline while it fills a line or drains a write over a req/ack memory handshake.

Parameters:
- INDEX_W, 4, index bits; the cache holds 2**INDEX_W one-word lines.
- ADDR_W, 16, address width; tag width = ADDR_W - INDEX_W.
- DATA_W, 16, word width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_req  in  1  MEM stage has a valid load or store this cycle.
- d_we  in  1  1 = store, 0 = load; qualified by d_req.
- d_addr  in  ADDR_W  word address from the pipeline.
- d_dataout  in  DATA_W  store data from the pipeline.
- d_datain  out  DATA_W  load data to the pipeline.
- hit  out  1  load hit this cycle (combinational).
- miss  out  1  pipeline stall request (combinational).
- mem_req  out  1  memory transaction request.
- mem_we  out  1  memory write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack = 1.
- mem_ack  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split: index = d_addr[INDEX_W-1:0], tag = d_addr[ADDR_W-1:INDEX_W]. Each line holds valid, tag and data.
- On reset (async assert):
  - all valid bits cleared, state = IDLE;
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
  - d_datain = 0, hit = 0, miss = 0.
- Data and tag arrays are not cleared by reset.
- State machine IDLE / FILL / WRITE:
  - IDLE, d_req & !d_we & valid & tag match:
    - hit = 1, miss = 0;
    - d_datain = line data in the same cycle (zero-latency hit).
  - IDLE, load miss:
    - miss = 1;
    - next cycle: state = FILL, mem_req = 1, mem_we = 0, mem_addr = d_addr (registered).
  - IDLE, d_req & d_we:
    - miss = 1;
    - next cycle: state = WRITE, mem_req = 1, mem_we = 1, mem_addr / mem_wdata registered.
    - If the line is valid and the tag matches, the line data is updated with d_dataout in the same edge.
    - A store miss does not allocate.
  - FILL: mem_req held high until mem_ack. On the ack edge:
    - the line is written with valid = 1, tag and mem_rdata;
    - mem_req drops and state returns to IDLE.
    - Next cycle the held request hits, miss = 0 and d_datain = the filled data.
  - WRITE: mem_req and mem_we held until mem_ack. On the ack edge: mem_req = 0, mem_we = 0, state = IDLE.
    - While the store is still presented, miss = 0 in the cycle after ack; the pipeline then advances.
    - To prevent a re-issue, a one-bit wr_done flag is set on ack and cleared when d_req falls or the address changes.
- Outside IDLE, miss = 1 whenever d_req = 1. Pipeline inputs are ignored until return to IDLE; the pipeline holds them stable while stalled.
- When d_req = 0: hit = 0 and miss = 0; d_datain holds its last value.
- mem_ack while in IDLE is ignored.
- Reset mid-FILL or mid-WRITE aborts the transaction immediately: mem_req drops, valid bits clear, and any late ack is ignored.
- Index wrap: addresses differing only above INDEX_W alias the same line; a fill overwrites it.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - adds 16-bit outputs hit_cnt and miss_cnt;
  - hit_cnt increments per load hit cycle, miss_cnt per IDLE→FILL transition;
  - both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, FILL, WRITE);
  - default ADDR_W / DATA_W / INDEX_W constants;
  - TAG_W derivation function.
- Sub-module dcache_array:
  - valid / tag / data storage;
  - combinational read port by index;
  - one synchronous write port (valid, tag, data);
  - async valid clear on reset.
- The controller FSM stays in dcache_ctrl.

Test Plan:
- Cold load 16'h0023, memory returns 16'hBEEF after 3 cycles → miss = 1 for 4 cycles, one FILL request at mem_addr 0023, then hit = 1 with d_datain = BEEF.
- Repeat load 16'h0023 → hit = 1 in the same cycle, no mem_req.
- Store 16'h0023 ← 16'h1234 (hit line) → mem_we pulse at addr 0023 with data 1234; a subsequent load hits with 1234.
- Store miss 16'h0045 ← 16'h00AA, then load 0045 → store does not allocate; the load misses and fills from memory.
- Alias: load 16'h0013 after 0023 is cached (same index 3) → miss, fill replaces the line; reloading 0023 misses again.
- Assert reset during FILL before ack → mem_req = 0 immediately; a late ack is ignored; after reset, load 0023 misses.
